// File: rtl/pattern_serializer.sv
// pattern_serializer
//   Parallel-to-serial bit source feeding the sequence detector. WIDTH-bit
//   words are accepted into a one-deep holding buffer over a load/ready
//   handshake and shifted out MSB-first on x, one bit per DIV mclk cycles.
//   The bit-period strobe (tick) is generated internally from mclk, so
//   consecutive buffered words stream out with no gap between them.
//
// Ports
//   mclk     in   master clock, all state on the rising edge
//   reset    in   asynchronous active-low reset
//   load     in   write din into the holding buffer (taken only while ready)
//   din      in   pattern word, bit WIDTH-1 sent first
//   ready    out  holding buffer empty (registered)
//   x        out  serial data
//   x_valid  out  x carries pattern data
//   tick     out  one-mclk bit-period strobe
//   bit_idx  out  index of the bit currently on x
module pattern_serializer #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic                     mclk,
   input  logic                     reset,
   input  logic                     load,
   input  logic [WIDTH-1:0]         din,
   output logic                     ready,
   output logic                     x,
   output logic                     x_valid,
   output logic                     tick,
   output logic [$clog2(WIDTH)-1:0] bit_idx
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int CNT_W = $clog2(DIV);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DIV - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] div_cnt;
   logic [WIDTH-1:0] hold, hold_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic             full, full_nxt;
   logic             take;

   // Free-running bit-period divider, independent of the handshake.
   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
      end else if (div_cnt == CNT_TOP) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CNT_W'(1);
      end
   end

   assign tick = (div_cnt == CNT_TOP);

   // The shift register is zeroed whenever the shifter goes idle, so its MSB
   // doubles as the x output in both states.
   assign x       = shreg[WIDTH-1];
   assign x_valid = (state == SHIFT);

   always_comb begin
      state_nxt = state;
      shreg_nxt = shreg;
      idx_nxt   = bit_idx;
      hold_nxt  = hold;
      full_nxt  = full;
      take      = 1'b0;

      if (tick) begin
         case (state)
            IDLE: begin
               if (full) begin
                  take = 1'b1;
               end
            end
            SHIFT: begin
               if (bit_idx != '0) begin
                  shreg_nxt = shreg << 1;
                  idx_nxt   = bit_idx - IDX_W'(1);
               end else if (full) begin
                  take = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  shreg_nxt = '0;
                  idx_nxt   = '0;
               end
            end
            default: begin
               state_nxt = IDLE;
               shreg_nxt = '0;
               idx_nxt   = '0;
            end
         endcase
      end

      // Buffer-to-shifter transfer; also covers the seamless word boundary.
      if (take) begin
         state_nxt = SHIFT;
         shreg_nxt = hold;
         idx_nxt   = IDX_TOP;
         full_nxt  = 1'b0;
      end

      // ready is low whenever full is set, so an accepted load never
      // coincides with a transfer and a buffered word is never overwritten.
      if (load && ready) begin
         hold_nxt = din;
         full_nxt = 1'b1;
      end
   end

   always_ff @(posedge mclk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         hold    <= '0;
         full    <= 1'b0;
         ready   <= 1'b1;
      end else begin
         state   <= state_nxt;
         shreg   <= shreg_nxt;
         bit_idx <= idx_nxt;
         hold    <= hold_nxt;
         full    <= full_nxt;
         ready   <= !full_nxt;
      end
   end

endmodule
